// File: rtl/sapho_fx_pkg.sv
// -----------------------------------------------------------------------------
// sapho_fx_pkg
// Shared definitions for the fixed-point datapath:
//   - NUBITS_DEF : default data word width (matches the ALU)
//   - clog2()    : ceiling log2, used to size counters and indices
//   - stk_op_e   : stack opcode encoding {push, pop}, shared with the
//                  control unit so both sides agree on the bit patterns
// -----------------------------------------------------------------------------
package sapho_fx_pkg;

    localparam int NUBITS_DEF = 32;

    // Bit 1 = push, bit 0 = pop; the encoding is the raw {push, pop} pair.
    typedef enum logic [1:0] {
        STK_NONE = 2'b00,
        STK_POP  = 2'b01,
        STK_PUSH = 2'b10,
        STK_REPL = 2'b11
    } stk_op_e;

    // Ceiling log2: clog2(1)=0, clog2(8)=3, clog2(9)=4.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >>> 1;
        end
        return res;
    endfunction

endpackage : sapho_fx_pkg

// File: rtl/stk_lifo.sv
// -----------------------------------------------------------------------------
// stk_lifo
// LIFO data stack with saturating occupancy and sticky error flags.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, pop     : stack request; both together replace the top entry
//   din           : word written on push / replace
//   err_clr       : clears ovf/udf (a same-cycle error event wins)
//   top           : mem[level-1], combinational; 0 when empty
//   level         : occupancy 0..SDEPTH
//   full, empty   : level == SDEPTH / level == 0
//   ovf, udf      : sticky push-while-full / pop-while-empty
// -----------------------------------------------------------------------------
module stk_lifo
    import sapho_fx_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int SDEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [NUBITS-1:0]              din,
    input  logic                           err_clr,
    output logic [NUBITS-1:0]              top,
    output logic [clog2(SDEPTH+1)-1:0]     level,
    output logic                           full,
    output logic                           empty,
    output logic                           ovf,
    output logic                           udf
);

    localparam int SPW = clog2(SDEPTH + 1);
    localparam int IW  = clog2(SDEPTH);

    logic [NUBITS-1:0] mem [SDEPTH];

    stk_op_e          op;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    wr_idx;
    logic             wr_en;
    logic [SPW-1:0]   level_nxt;
    logic             ovf_evt;
    logic             udf_evt;

    assign op      = stk_op_e'({push, pop});
    assign full    = (level == SPW'(SDEPTH));
    assign empty   = (level == '0);
    assign top_idx = IW'(level - SPW'(1));

    // Every entry below level has been written since reset, so masking the
    // empty case is all that keeps X off the output.
    assign top = empty ? '0 : mem[top_idx];

    // Next-state decision, made on the pre-edge level.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = top_idx;
        level_nxt = level;
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;
        case (op)
            STK_PUSH: begin
                if (full) begin
                    ovf_evt = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    wr_idx    = IW'(level);
                    level_nxt = level + SPW'(1);
                end
            end
            STK_POP: begin
                if (empty) udf_evt = 1'b1;
                else       level_nxt = level - SPW'(1);
            end
            STK_REPL: begin
                // Overwrite in place: legal when full, so never an overflow.
                if (empty) udf_evt = 1'b1;
                else       wr_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: the storage array has no reset; level=0 makes its contents
    // unreachable, and leaving it unreset lets it map onto plain RAM.
    // A same-cycle rst still blocks the write.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            level <= level_nxt;
            ovf   <= ovf_evt | (ovf & ~err_clr);
            udf   <= udf_evt | (udf & ~err_clr);
        end
    end

endmodule : stk_lifo

// File: rtl/ula_fx_opr.sv
// -----------------------------------------------------------------------------
// ula_fx_opr
// Operand stage of the fixed-point ALU: accumulator, zero flag and the
// operand-1 mux between the stack top and memory read data.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   acc_en            : load acc/zero from ula_out/ula_zero
//   ula_out, ula_zero : ALU result and its is_zero flag
//   push, pop         : stack request (push stores the pre-edge acc)
//   sel_stk           : 1 -> in1 = stack top, 0 -> in1 = mem_in
//   mem_in            : data memory read word
//   err_clr           : clear sticky ovf/udf
//   in1, in2          : ALU operands (in1 combinational, in2 = acc)
//   zero              : registered zero flag for conditional jumps
//   level, full, empty, ovf, udf : stack status
// -----------------------------------------------------------------------------
module ula_fx_opr
    import sapho_fx_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int SDEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           acc_en,
    input  logic [NUBITS-1:0]              ula_out,
    input  logic                           ula_zero,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           sel_stk,
    input  logic [NUBITS-1:0]              mem_in,
    input  logic                           err_clr,
    output logic [NUBITS-1:0]              in1,
    output logic [NUBITS-1:0]              in2,
    output logic                           zero,
    output logic [clog2(SDEPTH+1)-1:0]     level,
    output logic                           full,
    output logic                           empty,
    output logic                           ovf,
    output logic                           udf
);

    logic [NUBITS-1:0] acc;
    logic [NUBITS-1:0] top;

    // The stack captures acc as it was before this edge, so a push together
    // with acc_en stores the old value while acc loads the new result.
    stk_lifo #(
        .NUBITS (NUBITS),
        .SDEPTH (SDEPTH)
    ) u_stk (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (acc),
        .err_clr (err_clr),
        .top     (top),
        .level   (level),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .udf     (udf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            zero <= 1'b1;
        end else if (acc_en) begin
            acc  <= ula_out;
            zero <= ula_zero;
        end
    end

    assign in1 = sel_stk ? top : mem_in;
    assign in2 = acc;

endmodule : ula_fx_opr

// File: tb/tb_ula_fx_opr.sv
// -----------------------------------------------------------------------------
// tb_ula_fx_opr
// Directed and randomized stimulus against a queue-based reference model of
// the operand stage (accumulator, zero flag, LIFO stack, sticky errors).
// -----------------------------------------------------------------------------
module tb_ula_fx_opr;

    localparam int NUBITS = 32;
    localparam int SDEPTH = 8;
    localparam int SPW    = 4;

    logic              clk;
    logic              rst;
    logic              acc_en;
    logic [NUBITS-1:0] ula_out;
    logic              ula_zero;
    logic              push;
    logic              pop;
    logic              sel_stk;
    logic [NUBITS-1:0] mem_in;
    logic              err_clr;
    logic [NUBITS-1:0] in1;
    logic [NUBITS-1:0] in2;
    logic              zero;
    logic [SPW-1:0]    level;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              udf;

    ula_fx_opr #(
        .NUBITS (NUBITS),
        .SDEPTH (SDEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .acc_en   (acc_en),
        .ula_out  (ula_out),
        .ula_zero (ula_zero),
        .push     (push),
        .pop      (pop),
        .sel_stk  (sel_stk),
        .mem_in   (mem_in),
        .err_clr  (err_clr),
        .in1      (in1),
        .in2      (in2),
        .zero     (zero),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .udf      (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [NUBITS-1:0] m_acc;
    logic              m_zero;
    logic              m_ovf;
    logic              m_udf;
    logic [NUBITS-1:0] m_stk [$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUBITS-1:0] model_top();
        if (m_stk.size() == 0) return '0;
        return m_stk[$];
    endfunction

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic ovf_ev;
        logic udf_ev;
        ovf_ev = 1'b0;
        udf_ev = 1'b0;
        if (rst) begin
            m_acc  = '0;
            m_zero = 1'b1;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_stk.delete();
        end else begin
            if (push && pop) begin
                if (m_stk.size() == 0) udf_ev = 1'b1;
                else                   m_stk[m_stk.size()-1] = m_acc;
            end else if (push) begin
                if (m_stk.size() == SDEPTH) ovf_ev = 1'b1;
                else                        m_stk.push_back(m_acc);
            end else if (pop) begin
                if (m_stk.size() == 0) udf_ev = 1'b1;
                else                   void'(m_stk.pop_back());
            end
            m_ovf = ovf_ev | (m_ovf & ~err_clr);
            m_udf = udf_ev | (m_udf & ~err_clr);
            if (acc_en) begin
                m_acc  = ula_out;
                m_zero = ula_zero;
            end
        end
    endtask

    // Compares every output against the model; exercises both mux legs.
    task automatic check_all(input string tag);
        logic [NUBITS-1:0] mem_exp;
        check({tag, ".in2"},   in2,          m_acc);
        check({tag, ".zero"},  32'(zero),    32'(m_zero));
        check({tag, ".level"}, 32'(level),   32'(m_stk.size()));
        check({tag, ".full"},  32'(full),    32'(m_stk.size() == SDEPTH));
        check({tag, ".empty"}, 32'(empty),   32'(m_stk.size() == 0));
        check({tag, ".ovf"},   32'(ovf),     32'(m_ovf));
        check({tag, ".udf"},   32'(udf),     32'(m_udf));
        sel_stk = 1'b1;
        #1;
        check({tag, ".in1_stk"}, in1, model_top());
        mem_exp = $urandom;
        mem_in  = mem_exp;
        sel_stk = 1'b0;
        #1;
        check({tag, ".in1_mem"}, in1, mem_exp);
    endtask

    task automatic step(input logic r, input logic ae, input logic [NUBITS-1:0] uo,
                        input logic uz, input logic ps, input logic pp,
                        input logic ec, input string tag);
        @(negedge clk);
        rst      = r;
        acc_en   = ae;
        ula_out  = uo;
        ula_zero = uz;
        push     = ps;
        pop      = pp;
        err_clr  = ec;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst      = 1'b0;
        acc_en   = 1'b0;
        ula_out  = '0;
        ula_zero = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        sel_stk  = 1'b0;
        mem_in   = '0;
        err_clr  = 1'b0;
        m_acc    = '0;
        m_zero   = 1'b1;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;

        // Reset for two cycles while acc_en tries to load 5, then idle
        step(1'b1, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, "rst0");
        step(1'b1, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, "rst1");
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
        check("rst_in2",   in2,         32'd0);
        check("rst_zero",  32'(zero),   32'd1);
        check("rst_empty", 32'(empty),  32'd1);

        // Load 7, then push-then-load 9
        step(1'b0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, "load7");
        step(1'b0, 1'b1, 32'd9, 1'b0, 1'b1, 1'b0, 1'b0, "push_load9");
        check("pl_level", 32'(level), 32'd1);
        check("pl_in2",   in2,        32'd9);
        sel_stk = 1'b1;
        #1;
        check("pl_top", in1, 32'd7);

        // Fill with 1..8, then overflow, then clear
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_fill");
        step(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, "load1");
        for (int v = 2; v <= 8; v++) begin
            step(1'b0, 1'b1, 32'(v), 1'b0, 1'b1, 1'b0, 1'b0, "fill");
        end
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "fill8");
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "push_full");
        check("full_level", 32'(level), 32'd8);
        check("full_ovf",   32'(ovf),   32'd1);
        sel_stk = 1'b1;
        #1;
        check("full_top", in1, 32'd8);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_clr");
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Replace while full
        step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, "load55");
        step(1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, "repl_full");
        check("repl_level", 32'(level), 32'd8);
        check("repl_ovf",   32'(ovf),   32'd0);
        sel_stk = 1'b1;
        #1;
        check("repl_top", in1, 32'h55);

        // Pop to empty from tops 3,4
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_pop");
        step(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, "load3");
        step(1'b0, 1'b1, 32'd4, 1'b0, 1'b1, 1'b0, 1'b0, "push3");
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "push4");
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, "pop1");
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, "pop2");
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, "pop3");
        check("udf_set",    32'(udf),   32'd1);
        check("udf_level0", 32'(level), 32'd0);

        // Error event with err_clr in the same cycle: set wins
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, "udf_set_wins");
        check("set_wins", 32'(udf), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, "udf_clr");

        // Replace while empty
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, "repl_empty");
        check("repl_empty_udf", 32'(udf), 32'd1);

        // Reset coinciding with a push at level 3
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");
        step(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, "mid_load1");
        step(1'b0, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, "mid_push1");
        step(1'b0, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, "mid_push2");
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "mid_push3");
        check("mid_level3", 32'(level), 32'd3);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_with_push");
        check("rstp_level", 32'(level), 32'd0);
        check("rstp_ovf",   32'(ovf),   32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 1'($urandom),
                 32'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 7) == 0),
                 "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ula_fx_opr
